// File: rtl/rfile_host_pkg.sv
// Shared definitions for the RSSI-file host: FSM state encoding, record
// length and the byte position of every field inside a job record.
package rfile_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SYNC,
        RUN,
        RESP
    } state_t;

    localparam int unsigned RECORD_BYTES = 21;

    // Anchor coordinates, one byte each
    localparam logic [4:0] IDX_AX   = 5'd0;
    localparam logic [4:0] IDX_AY   = 5'd1;
    localparam logic [4:0] IDX_BX   = 5'd2;
    localparam logic [4:0] IDX_BY   = 5'd3;
    localparam logic [4:0] IDX_CX   = 5'd4;
    localparam logic [4:0] IDX_CY   = 5'd5;
    // RSSI words, 3 bytes MSB first (first byte contributes its low nibble)
    localparam logic [4:0] IDX_RA0  = 5'd6;
    localparam logic [4:0] IDX_RA1  = 5'd7;
    localparam logic [4:0] IDX_RA2  = 5'd8;
    localparam logic [4:0] IDX_RB0  = 5'd9;
    localparam logic [4:0] IDX_RB1  = 5'd10;
    localparam logic [4:0] IDX_RB2  = 5'd11;
    localparam logic [4:0] IDX_RC0  = 5'd12;
    localparam logic [4:0] IDX_RC1  = 5'd13;
    localparam logic [4:0] IDX_RC2  = 5'd14;
    // Calibration values, 2 bytes MSB first
    localparam logic [4:0] IDX_VA0  = 5'd15;
    localparam logic [4:0] IDX_VA1  = 5'd16;
    localparam logic [4:0] IDX_VB0  = 5'd17;
    localparam logic [4:0] IDX_VB1  = 5'd18;
    localparam logic [4:0] IDX_VC0  = 5'd19;
    localparam logic [4:0] IDX_VC1  = 5'd20;
    localparam logic [4:0] IDX_LAST = 5'(RECORD_BYTES - 1);

endpackage

// File: rtl/rfile_rec_loader.sv
// Job record loader: counts accepted bytes and demultiplexes each one into
// the engine-facing field registers. Fields only change on an accepted byte.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   accept       - a record byte is transferred this cycle
//   data         - the record byte
//   last         - the byte being accepted is the final record byte
//   A_x .. C_y   - anchor coordinates
//   rssiA..C     - 20-bit RSSI words
//   valueA..C    - 16-bit calibration values
module rfile_rec_loader
    import rfile_host_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic        last,
    output logic [7:0]  A_x,
    output logic [7:0]  A_y,
    output logic [7:0]  B_x,
    output logic [7:0]  B_y,
    output logic [7:0]  C_x,
    output logic [7:0]  C_y,
    output logic [19:0] rssiA,
    output logic [19:0] rssiB,
    output logic [19:0] rssiC,
    output logic [15:0] valueA,
    output logic [15:0] valueB,
    output logic [15:0] valueC
);

    logic [4:0] byte_cnt;

    assign last = accept && (byte_cnt == IDX_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            A_x      <= '0;
            A_y      <= '0;
            B_x      <= '0;
            B_y      <= '0;
            C_x      <= '0;
            C_y      <= '0;
            rssiA    <= '0;
            rssiB    <= '0;
            rssiC    <= '0;
            valueA   <= '0;
            valueB   <= '0;
            valueC   <= '0;
        end else if (accept) begin
            // Wrap to 0 after the final byte so the next job starts clean
            byte_cnt <= last ? '0 : byte_cnt + 5'd1;
            case (byte_cnt)
                IDX_AX:  A_x            <= data;
                IDX_AY:  A_y            <= data;
                IDX_BX:  B_x            <= data;
                IDX_BY:  B_y            <= data;
                IDX_CX:  C_x            <= data;
                IDX_CY:  C_y            <= data;
                IDX_RA0: rssiA[19:16]   <= data[3:0];
                IDX_RA1: rssiA[15:8]    <= data;
                IDX_RA2: rssiA[7:0]     <= data;
                IDX_RB0: rssiB[19:16]   <= data[3:0];
                IDX_RB1: rssiB[15:8]    <= data;
                IDX_RB2: rssiB[7:0]     <= data;
                IDX_RC0: rssiC[19:16]   <= data[3:0];
                IDX_RC1: rssiC[15:8]    <= data;
                IDX_RC2: rssiC[7:0]     <= data;
                IDX_VA0: valueA[15:8]   <= data;
                IDX_VA1: valueA[7:0]    <= data;
                IDX_VB0: valueB[15:8]   <= data;
                IDX_VB1: valueB[7:0]    <= data;
                IDX_VC0: valueC[15:8]   <= data;
                IDX_VC1: valueC[7:0]    <= data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rfile_host.sv
// Host for the localisation engine: loads a 21-byte job record, holds the
// engine inputs stable, discards the first (stale) engine pass, captures the
// next pass result or a timeout, and offers it on a valid/ready port.
// Ports:
//   clk, rst                - clock, asynchronous active-low reset
//   in_valid/in_ready/in_data - job record byte stream
//   A_x..C_y, rssiA..C, valueA..C - engine-facing record fields
//   eng_out_valid, eng_xt, eng_yt - engine end-of-pass pulse and result
//   res_valid/res_ready, res_xt, res_yt, res_timeout - result port
//   busy                    - high whenever the FSM is not IDLE
module rfile_host
    import rfile_host_pkg::*;
#(
    parameter int unsigned TIMEOUT = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic [7:0]  A_x,
    output logic [7:0]  A_y,
    output logic [7:0]  B_x,
    output logic [7:0]  B_y,
    output logic [7:0]  C_x,
    output logic [7:0]  C_y,
    output logic [19:0] rssiA,
    output logic [19:0] rssiB,
    output logic [19:0] rssiC,
    output logic [15:0] valueA,
    output logic [15:0] valueB,
    output logic [15:0] valueC,
    input  logic        eng_out_valid,
    input  logic [7:0]  eng_xt,
    input  logic [7:0]  eng_yt,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_xt,
    output logic [7:0]  res_yt,
    output logic        res_timeout,
    output logic        busy
);

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    logic       timed_out;
    logic       accept;
    logic       rec_last;

    // in_ready is a registered copy of (state is IDLE or LOAD)
    assign accept    = in_valid && in_ready;
    assign wait_nxt  = (wait_cnt == TIMEOUT_W) ? wait_cnt : wait_cnt + 8'd1;
    assign timed_out = (wait_nxt == TIMEOUT_W);

    rfile_rec_loader u_loader (
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
        .data   (in_data),
        .last   (rec_last),
        .A_x    (A_x),
        .A_y    (A_y),
        .B_x    (B_x),
        .B_y    (B_y),
        .C_x    (C_x),
        .C_y    (C_y),
        .rssiA  (rssiA),
        .rssiB  (rssiB),
        .rssiC  (rssiC),
        .valueA (valueA),
        .valueB (valueB),
        .valueC (valueC)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_xt      <= '0;
            res_yt      <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (rec_last) begin
                        state    <= SYNC;
                        in_ready <= 1'b0;
                        wait_cnt <= '0;
                    end
                end
                SYNC, RUN: begin
                    // Engine pulse takes priority over a coincident timeout
                    if (eng_out_valid) begin
                        if (state == SYNC) begin
                            state    <= RUN;
                            wait_cnt <= '0;
                        end else begin
                            state       <= RESP;
                            res_valid   <= 1'b1;
                            res_xt      <= eng_xt;
                            res_yt      <= eng_yt;
                            res_timeout <= 1'b0;
                        end
                    end else begin
                        wait_cnt <= wait_nxt;
                        if (timed_out) begin
                            state       <= RESP;
                            res_valid   <= 1'b1;
                            res_xt      <= '0;
                            res_yt      <= '0;
                            res_timeout <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rfile_host.sv
module tb_rfile_host;

    localparam int unsigned TB_TIMEOUT = 127;

    typedef struct {
        logic [7:0]  ax, ay, bx, by, cx, cy;
        logic [19:0] ra, rb, rc;
        logic [3:0]  junk;
        logic [15:0] va, vb, vc;
        int unsigned mode;         // 0 silent engine, 1 periodic, 2 manual
        logic [7:0]  xt, yt;
        int unsigned gap_mod;
        int unsigned ready_delay;
        logic [7:0]  exp_xt, exp_yt;
        logic        exp_to;
    } vec_t;

    typedef struct packed {
        logic [7:0] xt;
        logic [7:0] yt;
        logic       to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  A_x, A_y, B_x, B_y, C_x, C_y;
    logic [19:0] rssiA, rssiB, rssiC;
    logic [15:0] valueA, valueB, valueC;
    logic        eng_out_valid;
    logic [7:0]  eng_xt, eng_yt;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_xt, res_yt;
    logic        res_timeout;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    int unsigned consumed = 0;
    int unsigned cyc = 0;
    int unsigned eng_mode = 0;
    logic        prev_eov = 1'b0;
    logic [7:0]  rec [21];
    exp_t        sb [$];
    exp_t        cur;
    vec_t        vecs [4];

    always #5 clk = ~clk;

    rfile_host #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .A_x           (A_x),
        .A_y           (A_y),
        .B_x           (B_x),
        .B_y           (B_y),
        .C_x           (C_x),
        .C_y           (C_y),
        .rssiA         (rssiA),
        .rssiB         (rssiB),
        .rssiC         (rssiC),
        .valueA        (valueA),
        .valueB        (valueB),
        .valueC        (valueC),
        .eng_out_valid (eng_out_valid),
        .eng_xt        (eng_xt),
        .eng_yt        (eng_yt),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_xt        (res_xt),
        .res_yt        (res_yt),
        .res_timeout   (res_timeout),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [155:0] dut_eng();
        return {A_x, A_y, B_x, B_y, C_x, C_y, rssiA, rssiB, rssiC, valueA, valueB, valueC};
    endfunction

    function automatic logic [155:0] vec_eng(input vec_t v);
        return {v.ax, v.ay, v.bx, v.by, v.cx, v.cy, v.ra, v.rb, v.rc, v.va, v.vb, v.vc};
    endfunction

    function automatic void build_rec(input vec_t v);
        rec[0]  = v.ax;  rec[1]  = v.ay;  rec[2] = v.bx;
        rec[3]  = v.by;  rec[4]  = v.cx;  rec[5] = v.cy;
        rec[6]  = {v.junk, v.ra[19:16]}; rec[7]  = v.ra[15:8]; rec[8]  = v.ra[7:0];
        rec[9]  = {v.junk, v.rb[19:16]}; rec[10] = v.rb[15:8]; rec[11] = v.rb[7:0];
        rec[12] = {v.junk, v.rc[19:16]}; rec[13] = v.rc[15:8]; rec[14] = v.rc[7:0];
        rec[15] = v.va[15:8]; rec[16] = v.va[7:0];
        rec[17] = v.vb[15:8]; rec[18] = v.vb[7:0];
        rec[19] = v.vc[15:8]; rec[20] = v.vc[7:0];
    endfunction

    // One cycle: remember the pulse the DUT just sampled, move to the next
    // falling edge and drive the periodic engine model.
    task automatic tick();
        prev_eov = eng_out_valid;
        @(negedge clk);
        cyc++;
        eng_out_valid = (eng_mode == 1) && ((cyc % 56) == 0);
    endtask

    // Drive n record bytes; the last one is accepted on the following edge.
    task automatic load_bytes(input int unsigned n, input int unsigned gap_mod);
        int unsigned idx = 0;
        int unsigned guard = 0;
        while (idx < n && guard < 300) begin
            tick();
            guard++;
            if (gap_mod != 0 && (guard % gap_mod) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = rec[idx];
                if (in_ready) begin
                    idx++;
                    consumed++;
                end
            end
        end
        check("load_done", 160'(idx), 160'(n));
    endtask

    task automatic compare_result();
        check("sb_nonempty", 160'(sb.size() != 0), 160'(1));
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            check("res_xt", 160'(res_xt), 160'(cur.xt));
            check("res_yt", 160'(res_yt), 160'(cur.yt));
            check("res_timeout", 160'(res_timeout), 160'(cur.to));
        end
    endtask

    task automatic hold_and_release(input int unsigned delay);
        logic hold_ok = 1'b1;
        for (int unsigned d = 0; d < delay; d++) begin
            tick();
            in_valid = 1'b1;
            in_data  = 8'hEE;
            if (in_ready) consumed++;
            if (!res_valid || res_xt !== cur.xt || res_yt !== cur.yt ||
                res_timeout !== cur.to || in_ready !== 1'b0)
                hold_ok = 1'b0;
        end
        check("resp_hold", 160'(hold_ok), 160'(1));
        tick();
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("return_idle", 160'({res_valid, in_ready, busy}), 160'(3'b010));
    endtask

    task automatic run_job(input vec_t v);
        int unsigned k = 0;
        int unsigned npulse = 0;
        logic got = 1'b0;
        logic stable_ok = 1'b1;
        consumed = 0;
        eng_mode = v.mode;
        eng_xt   = v.xt;
        eng_yt   = v.yt;
        build_rec(v);
        load_bytes(21, v.gap_mod);
        sb.push_back('{xt: v.exp_xt, yt: v.exp_yt, to: v.exp_to});
        for (int unsigned guard = 0; guard < 400 && !got; guard++) begin
            tick();
            in_valid = 1'b1;
            in_data  = 8'hEE;
            if (in_ready) consumed++;
            if (k >= 1 && prev_eov) npulse++;
            if (dut_eng() !== vec_eng(v)) stable_ok = 1'b0;
            if (res_valid) got = 1'b1;
            else k++;
        end
        check("res_valid_seen", 160'(got), 160'(1));
        check("eng_fields_stable", 160'(stable_ok), 160'(1));
        if (v.exp_to)
            check("timeout_latency", 160'(k), 160'(TB_TIMEOUT));
        else
            check("second_pulse_latency", 160'({npulse == 2, prev_eov}), 160'(2'b11));
        compare_result();
        hold_and_release(v.ready_delay);
        check("bytes_consumed", 160'(consumed), 160'(21));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic early;
        vecs[0] = '{ax: 8'd10, ay: 8'd20, bx: 8'd200, by: 8'd30, cx: 8'd100, cy: 8'd180,
                    ra: 20'hFFFC6, rb: 20'h0ABCD, rc: 20'h12345, junk: 4'h0,
                    va: 16'h1000, vb: 16'h2000, vc: 16'h3000, mode: 1, xt: 8'h3C, yt: 8'h5A,
                    gap_mod: 0, ready_delay: 0, exp_xt: 8'h3C, exp_yt: 8'h5A, exp_to: 1'b0};
        vecs[1] = '{ax: 8'd1, ay: 8'd2, bx: 8'd3, by: 8'd4, cx: 8'd5, cy: 8'd6,
                    ra: 20'h00001, rb: 20'h80000, rc: 20'h7FFFF, junk: 4'hA,
                    va: 16'h0001, vb: 16'h8000, vc: 16'hBEEF, mode: 0, xt: 8'h99, yt: 8'h66,
                    gap_mod: 3, ready_delay: 2, exp_xt: 8'h00, exp_yt: 8'h00, exp_to: 1'b1};
        vecs[2] = '{ax: 8'h55, ay: 8'hAA, bx: 8'h0F, by: 8'hF0, cx: 8'h33, cy: 8'hCC,
                    ra: 20'h5A5A5, rb: 20'hA5A5A, rc: 20'h00F00, junk: 4'hF,
                    va: 16'h1234, vb: 16'h5678, vc: 16'h9ABC, mode: 1, xt: 8'h11, yt: 8'h22,
                    gap_mod: 4, ready_delay: 30, exp_xt: 8'h11, exp_yt: 8'h22, exp_to: 1'b0};
        vecs[3] = '{ax: 8'hFF, ay: 8'hFF, bx: 8'hFF, by: 8'hFF, cx: 8'hFF, cy: 8'hFF,
                    ra: 20'hFFFFF, rb: 20'hFFFFF, rc: 20'hFFFFF, junk: 4'hF,
                    va: 16'hFFFF, vb: 16'hFFFF, vc: 16'hFFFF, mode: 1, xt: 8'hFF, yt: 8'h00,
                    gap_mod: 2, ready_delay: 1, exp_xt: 8'hFF, exp_yt: 8'h00, exp_to: 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        res_ready = 1'b0;
        eng_out_valid = 1'b0;
        eng_xt = '0;
        eng_yt = '0;
        #1 rst = 1'b0;
        #10;
        check("reset_eng_outs", 160'(dut_eng()), 160'(0));
        check("reset_result", 160'({res_valid, res_xt, res_yt, res_timeout, busy}), 160'(0));
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("in_ready_after_reset", 160'({in_ready, busy}), 160'(2'b10));

        for (int i = 0; i < 4; i++) run_job(vecs[i]);

        // Reset after byte 9 of a job: everything clears, no result appears.
        consumed = 0;
        build_rec(vecs[2]);
        eng_mode = 1;
        load_bytes(10, 0);
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midload_reset_outs", 160'(dut_eng()), 160'(0));
        check("midload_reset_state", 160'({res_valid, busy, in_ready}), 160'(3'b001));
        @(negedge clk);
        rst = 1'b1;
        run_job(vecs[0]);

        // Engine pulse lands on the RUN timeout cycle: the pulse wins.
        consumed = 0;
        build_rec(vecs[3]);
        eng_mode = 2;
        eng_xt = 8'h77;
        eng_yt = 8'h88;
        load_bytes(21, 0);
        sb.push_back('{xt: 8'h77, yt: 8'h88, to: 1'b0});
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        eng_out_valid = 1'b1;
        tick();
        eng_out_valid = 1'b0;
        early = 1'b0;
        for (int unsigned m = 1; m < TB_TIMEOUT; m++) begin
            tick();
            if (res_valid) early = 1'b1;
            if (m == TB_TIMEOUT - 1) eng_out_valid = 1'b1;
        end
        tick();
        eng_out_valid = 1'b0;
        check("run_no_early_result", 160'(early), 160'(0));
        check("run_edge_res_valid", 160'(res_valid), 160'(1));
        check("run_edge_fields", 160'(dut_eng()), 160'(vec_eng(vecs[3])));
        compare_result();
        hold_and_release(0);
        check("bytes_consumed", 160'(consumed), 160'(21));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rfile_host.md
RFILE_HOST -- requirements
Module: rfile_host

Interface
REQ-001 SHALL have parameter TIMEOUT, default 127: maximum cycles allowed in each engine-wait state.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: job byte present on in_data.
REQ-005 SHALL have port in_ready, output, 1 bit: host accepts a job byte this cycle.
REQ-006 SHALL have port in_data, input, 8 bits: job record byte stream.
REQ-007 SHALL have ports A_x, A_y, B_x, B_y, C_x, C_y, output, 8 bits each: anchor coordinates driven to the engine.
REQ-008 SHALL have ports rssiA, rssiB, rssiC, output, 20 bits each: RSSI words driven to the engine.
REQ-009 SHALL have ports valueA, valueB, valueC, output, 16 bits each: calibration values driven to the engine.
REQ-010 SHALL have port eng_out_valid, input, 1 bit: engine end-of-pass pulse.
REQ-011 SHALL have ports eng_xt and eng_yt, input, 8 bits each: engine result coordinates.
REQ-012 SHALL have port res_valid, output, 1 bit: result available.
REQ-013 SHALL have port res_ready, input, 1 bit: result consumer accepts.
REQ-014 SHALL have ports res_xt and res_yt, output, 8 bits each: captured result.
REQ-015 SHALL have port res_timeout, output, 1 bit: result invalid because the engine timed out.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SYNC, RUN and RESP.
REQ-018 IDLE: in_ready=1; an accepted byte (in_valid&in_ready) SHALL be stored as byte 0 and move the FSM to LOAD.
REQ-019 LOAD: in_ready=1; each accepted byte SHALL be stored at index byte_cnt (0..20); acceptance of byte 20 SHALL move the FSM to SYNC.
REQ-020 Record order SHALL be 21 bytes:
- bytes 0-5: A_x, A_y, B_x, B_y, C_x, C_y;
- bytes 6-14: rssiA, rssiB, rssiC, 3 bytes each, MSB first; only bits [3:0] of the first byte are used, upper nibble ignored;
- bytes 15-20: valueA, valueB, valueC, 2 bytes each, MSB first.
REQ-021 Engine-facing outputs SHALL change only on accepted bytes in IDLE/LOAD and SHALL be held stable in SYNC, RUN and RESP.
REQ-022 SYNC: in_ready=0; the first eng_out_valid (a pass started with stale or mixed inputs) SHALL be discarded and move the FSM to RUN.
REQ-023 RUN: the next eng_out_valid SHALL capture eng_xt into res_xt and eng_yt into res_yt, clear res_timeout, and move the FSM to RESP.
REQ-024 A wait counter SHALL clear on entry to SYNC and on entry to RUN, and increment each cycle in those states; reaching TIMEOUT SHALL move the FSM to RESP with res_timeout=1 and res_xt=res_yt=0.
REQ-025 If eng_out_valid and the TIMEOUT condition occur in the same cycle, eng_out_valid SHALL win.
REQ-026 RESP: res_valid=1 with res_xt, res_yt and res_timeout stable until res_valid&res_ready, then the FSM SHALL return to IDLE; res_valid SHALL never drop without that handshake.
REQ-027 Latency SHALL be 1 cycle from eng_out_valid in RUN to res_valid.
REQ-028 in_valid outside IDLE/LOAD SHALL be ignored with no byte consumed.
REQ-029 byte_cnt SHALL be 5 bits and never exceed 20; the wait counter SHALL be 8 bits and saturate at TIMEOUT.

Reset
REQ-030 Reset SHALL asynchronously force: FSM to IDLE, byte_cnt=0, wait counter=0, all engine-facing outputs to 0, res_valid=0, res_xt=0, res_yt=0, res_timeout=0, busy=0; with the FSM in IDLE, in_ready=1 after release.
REQ-031 Reset asserted mid-LOAD, SYNC, RUN or RESP SHALL abandon the job with no result emitted.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, RECORD_BYTES=21, and the record byte-index constants.
REQ-033 The record loader (byte_cnt plus byte-to-field demux) SHALL be one sub-module, rfile_rec_loader; the FSM and result capture SHALL stay in rfile_host.

Verification
REQ-034 Load 21 bytes with A=(10,20), B=(200,30), C=(100,180), rssiA=20'hFFFC6, valueA=16'h1000; engine model pulses eng_out_valid every 56 cycles with xt=8'h3C, yt=8'h5A -> outputs match the loaded fields, first pulse discarded, res_valid with res_xt=8'h3C, res_yt=8'h5A, res_timeout=0.
REQ-035 Engine model never pulses -> res_valid with res_timeout=1 and res_xt=res_yt=0 exactly TIMEOUT cycles after SYNC entry.
REQ-036 Hold res_ready=0 for 30 cycles in RESP -> result held stable, in_ready=0, no bytes consumed; then accepted, FSM to IDLE.
REQ-037 Assert rst after byte 9 -> all outputs return to 0; a subsequent full 21-byte job completes correctly.
REQ-038 eng_out_valid on the TIMEOUT cycle in RUN -> res_timeout=0 with engine values captured.
REQ-039 Toggle in_valid with gaps during LOAD and keep it asserted during SYNC -> only 21 bytes consumed; the engine-facing outputs do not change in SYNC or RUN.
